// File: rtl/reflet_ram_responder.sv
// Memory-side responder for the Reflet CPU bus: word array with registered reads,
// optional power-on zero fill (REFLET_RAM_CLEAR_EN), ready gating and sticky range error.
module reflet_ram_responder #(
    parameter int wordsize   = 16,
    parameter int depth_log2 = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_out,
    input  logic                write_en,
    output logic [wordsize-1:0] data_in,
    output logic                ready,
    output logic                bus_error,
    input  logic                error_clear
);
    localparam int BYTE_SHIFT = $clog2(wordsize / 8);
    localparam int IDX_TOP    = BYTE_SHIFT + depth_log2;
    localparam int WORDS      = 2 ** depth_log2;

    logic [wordsize-1:0]   mem [WORDS];
    logic [depth_log2-1:0] idx;
    logic                  in_range;
    logic                  serving;
    logic                  bus_we;
    logic                  mem_we;
    logic [depth_log2-1:0] mem_widx;
    logic [wordsize-1:0]   mem_wdata;
    logic [wordsize-1:0]   addr_q;
    logic [wordsize-1:0]   data_q;
    logic                  err_q;

    assign idx      = addr[BYTE_SHIFT +: depth_log2];
    assign in_range = (addr >> IDX_TOP) == '0;
    assign bus_we   = serving && enable && write_en && in_range;

`ifdef REFLET_RAM_CLEAR_EN
    // state   | meaning
    // S_CLEAR | zero-filling mem[cnt] every clock, bus ignored, ready low
    // S_READY | normal bus service
    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [depth_log2-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (cnt == '1) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
        endcase
    end

    assign serving   = (state == S_READY);
    assign ready     = serving;
    assign mem_we    = !serving || bus_we;
    assign mem_widx  = serving ? idx : cnt;
    assign mem_wdata = serving ? data_out : '0;
`else
    logic ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign serving   = 1'b1;
    assign ready     = ready_q;
    assign mem_we    = bus_we;
    assign mem_widx  = idx;
    assign mem_wdata = data_out;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    // Read samples mem before the same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (enable) addr_q <= addr;

            if (!serving)    data_q <= '0;
            else if (enable) data_q <= in_range ? mem[idx] : '0;

            if (error_clear)
                err_q <= 1'b0;
            else if (serving && enable && !in_range && (write_en || addr != addr_q))
                err_q <= 1'b1;
        end
    end

    assign data_in   = data_q;
    assign bus_error = err_q;

endmodule

// File: tb/tb_reflet_ram_responder.sv
// Self-checking bench for reflet_ram_responder (wordsize 16, 16 words); follows REFLET_RAM_CLEAR_EN.
module tb_reflet_ram_responder;
    localparam int W     = 16;
    localparam int D     = 4;
    localparam int WORDS = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] addr = '0;
    logic [W-1:0] data_out = '0;
    logic         write_en = 1'b0;
    logic [W-1:0] data_in;
    logic         ready;
    logic         bus_error;
    logic         error_clear = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: byte-addressed word store plus sticky flag
    logic [W-1:0] m_mem [WORDS];
    logic [W-1:0] m_data;
    logic         m_err;
    logic [W-1:0] m_addr;

    typedef struct {
        logic         en;
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic         we;
        logic         ec;
        logic [W-1:0] xd;
        logic         xe;
    } vec_t;

    vec_t tbl[20];

    reflet_ram_responder #(.wordsize(W), .depth_log2(D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_out(data_out),
        .write_en(write_en), .data_in(data_in), .ready(ready), .bus_error(bus_error),
        .error_clear(error_clear)
    );

    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic we, input logic ec);
        enable = en; addr = a; data_out = d; write_en = we; error_clear = ec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset_zero(input logic [W-1:0] last_addr);
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        m_data = '0;
        m_err  = 1'b0;
        m_addr = last_addr;
    endtask

    // One bus cycle: predict from the model, apply, compare after the edge
    task automatic apply(input string tag, input logic en, input logic [W-1:0] a,
                         input logic [W-1:0] d, input logic we, input logic ec);
        logic ok;
        int   wi;
        ok = (int'(a) < WORDS * 2);
        wi = (int'(a) / 2) % WORDS;
        if (en) begin
            m_data = ok ? m_mem[wi] : '0;
            if (we && ok) m_mem[wi] = d;
            if (!ok && (we || a != m_addr)) m_err = 1'b1;
            m_addr = a;
        end
        if (ec) m_err = 1'b0;
        drive(en, a, d, we, ec);
        tick();
        check16({tag, "_data"}, data_in, m_data);
        check1({tag, "_err"}, bus_error, m_err);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h0006, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b1, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 16'h0004, 16'h1234, 1'b1, 1'b0, 16'hAAAA, 1'b0};
        tbl[5]  = '{1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0};
        tbl[6]  = '{1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[9]  = '{1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 16'h0002, 16'h7777, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 16'h001E, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 16'h001F, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0};
        tbl[14] = '{1'b1, 16'h001F, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0};
        tbl[15] = '{1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0};
        tbl[16] = '{1'b1, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[17] = '{1'b1, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[18] = '{1'b1, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[19] = '{1'b1, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check16("rst_data", data_in, 16'h0000);
        check1("rst_ready", ready, 1'b0);
        check1("rst_err", bus_error, 1'b0);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;

`ifdef REFLET_RAM_CLEAR_EN
        // Clear runs with enable low and drops bus writes and errors
        for (int k = 1; k <= WORDS; k++) begin
            if (k == 3 || k == 4)       drive(1'b1, 16'h0040, 16'h1111, 1'b1, 1'b0);
            else if (k >= 5 && k <= 8)  drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            else if (k >= 9 && k <= 12) drive(1'b1, 16'h0000, 16'hDEAD, 1'b1, 1'b0);
            else                        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            if (k == 4)  check1("clr_err", bus_error, 1'b0);
            if (k == 8)  check16("clr_data", data_in, 16'h0000);
            if (k == 15) check1("clr_ready_lo", ready, 1'b0);
            if (k == 16) check1("clr_ready_hi", ready, 1'b1);
        end
        model_reset_zero(16'h0000);
`else
        tick();
        check1("boot_ready", ready, 1'b1);
        for (int i = 0; i < WORDS; i++) begin
            drive(1'b1, 16'(i * 2), 16'h0000, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        model_reset_zero(16'h0000);
`endif

        for (int i = 0; i < WORDS; i++) begin
            apply("sweep", 1'b1, 16'(i * 2), 16'h0000, 1'b0, 1'b0);
            check16("sweep_zero", data_in, 16'h0000);
        end

        foreach (tbl[i]) begin
            apply("tbl_model", tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].ec);
            check16($sformatf("tbl%0d_data", i), data_in, tbl[i].xd);
            check1($sformatf("tbl%0d_err", i), bus_error, tbl[i].xe);
        end

        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] a;
            int r;
            r = int'($urandom_range(0, 7));
            if (r == 0)      a = 16'($urandom_range(16'h0020, 16'hFFFF));
            else if (r == 1) a = m_addr;
            else             a = 16'($urandom_range(0, 31));
            apply("rand", $urandom_range(0, 4) != 0, a, 16'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        apply("pre_rst_wr", 1'b1, 16'h000E, 16'h1357, 1'b1, 1'b0);
        apply("pre_rst_rd", 1'b1, 16'h000E, 16'h0000, 1'b0, 1'b0);
        apply("pre_rst_err", 1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check16("arst_data", data_in, 16'h0000);
        check1("arst_ready", ready, 1'b0);
        check1("arst_err", bus_error, 1'b0);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

`ifdef REFLET_RAM_CLEAR_EN
        repeat (7) tick();
        reset = 1'b0;
        #1;
        check1("mid_rst_ready", ready, 1'b0);
        tick();
        reset = 1'b1;
        for (int k = 1; k <= WORDS; k++) begin
            tick();
            if (k == 15) check1("re_clr_ready_lo", ready, 1'b0);
            if (k == 16) check1("re_clr_ready_hi", ready, 1'b1);
        end
        drive(1'b1, 16'h000E, 16'h0000, 1'b0, 1'b0);
        tick();
        check16("re_clr_read_0e", data_in, 16'h0000);
`else
        tick();
        check1("re_boot_ready", ready, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/reflet_ram_responder.md
# reflet_ram_responder

Memory-side responder for the Reflet CPU memory bus. It answers the byte-addressed `addr` / `data_out` / `write_en` / `data_in` bus driven by the CPU address unit, backed by an internal word array with registered reads. It performs whole-word writes only; the CPU side has already merged sub-word data into the word. It also provides a power-on zero-fill sequence, a `ready` output that gates the CPU `enable`, and sticky out-of-range error reporting.

## Interface
- `wordsize`, 16: bus width in bits; multiple of 8, at least 8.
- `depth_log2`, 10: log2 of the number of words in the array.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  bus-side clock enable. When low, the read register, array writes and the error flag hold.
- `addr`  in  `wordsize`  byte address from the CPU.
- `data_out`  in  `wordsize`  write data from the CPU (full merged word).
- `write_en`  in  1  write strobe from the CPU.
- `data_in`  out  `wordsize`  read data returned to the CPU.
- `ready`  out  1  high once the array is usable. Intended to drive the CPU `enable`.
- `bus_error`  out  1  sticky flag: an out-of-range access occurred.
- `error_clear`  in  1  synchronous clear of `bus_error`.

## Operation
- Word index = `addr >> $clog2(wordsize/8)`, truncated to `depth_log2` bits. The low byte-offset bits are ignored; alignment is the CPU's job.
- In range means every `addr` bit above the index field is 0. The top valid byte address is `2^depth_log2 * wordsize/8 - 1`.
- State machine, two states:
  - CLEAR: entered on reset. Clear counter = 0, `ready` = 0, `data_in` = 0. Bus writes are dropped and `bus_error` is not set.
  - READY: normal service.
- CLEAR runs every clock regardless of `enable`:
  - writes 0 to `mem[cnt]`, then `cnt <= cnt + 1`;
  - after writing index `2^depth_log2 - 1`, moves to READY on the same edge.
- READY, with `enable` high, on each edge:
  - read: `data_in <= in_range ? mem[idx] : 0`;
  - write: if `write_en && in_range`, `mem[idx] <= data_out`;
  - error: if `(write_en || addr changed) && !in_range`, `bus_error <= 1`. Address change is detected against a registered copy of `addr`, so one out-of-range read sets the flag once.
- Read-during-write to the same index is read-first: `data_in` shows the old word for one cycle and the new word on the following edge.
- `error_clear` has priority over a simultaneous set: the flag clears and the new error is lost.
- Reset asserted mid-CLEAR or mid-READY: immediate return to CLEAR with `cnt` = 0. The full clear restarts after release; array contents written before are not guaranteed.

## Timing
- Reset values: `data_in` = 0, `ready` = 0, `bus_error` = 0.
- Read latency: one cycle. `data_in` is valid on the first edge after `addr` is stable. This meets the CPU reader, which samples two edges after its request.
- Write takes effect on the edge where `write_en` is high; `write_en` is treated as a single-cycle pulse.
- Clear duration: `ready` rises on the `2^depth_log2`-th rising edge after reset deassertion.
- `bus_error` rises one edge after the offending access. It falls one edge after `error_clear`.

## Configuration
- `REFLET_RAM_CLEAR_EN` defined: CLEAR state and counter are compiled in, behaving as above.
- `REFLET_RAM_CLEAR_EN` undefined: no counter and no CLEAR state. Reset enters READY directly, with `ready` = 0 during reset and 1 from the first edge after release. Array contents after power-up are undefined.

## Test plan
- `wordsize`=16, `depth_log2`=4, macro on. Release reset, then read every address 0..30 step 2 → `ready` rises on edge 16 after release; all reads return 0x0000.
- Write 0xBEEF at `addr` 0x0006, then read 0x0006 and 0x0007 → both return 0xBEEF one cycle after the address is presented.
- Write 0x1234 to 0x0004 in the same cycle its old value 0xAAAA is read → `data_in` = 0xAAAA on the next edge, 0x1234 on the edge after.
- Write 0x5555 to 0x0020 → array unchanged (0x0000 at 0x0000), `bus_error` = 1. Pulse `error_clear` together with another out-of-range read → `bus_error` = 0.
- Assert reset at clear count 7, release → `ready` still rises 16 edges after the second release, and a read of 0x000E returns 0.
- Macro off → `ready` = 1 on the first edge after release. With `enable` low, a write of 0x7777 to 0x0002 is ignored: reading it back with `enable` high returns the prior value.
